i2c_target_regs: RTL and testbench

I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

---
 rtl/i2c_target_regs.sv | 235 +++++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regs.sv
// I2C target exposing four 8-bit registers behind a 2-bit auto-incrementing pointer.
// A write transaction is address+W, pointer byte, then any number of data bytes.
// A read transaction is address+R, then bytes streamed from the pointer onward.
// An optional clock stretch follows every ACK that this target drives.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   scl_i, sda_i   raw bus line levels (synchronised internally)
//   scl_oe         1 = pull SCL low (clock stretch)
//   sda_oe         1 = pull SDA low
//   stretch_cycles clk cycles of SCL stretch after each target ACK, 0 = none
//   regs           register file, regs[8k+7:8k] = reg k
//   wr_strobe      one-cycle pulse per register write
//   busy           high from address match until STOP / IDLE / IGNORE
module i2c_target_regs #(
  parameter logic [6:0] TARGET_ADDR = 7'b0101010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        scl_oe,
  output logic        sda_oe,
  input  logic [7:0]  stretch_cycles,
  output logic [31:0] regs,
  output logic        wr_strobe,
  output logic        busy
);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StPtr, StPtrAck, StWdata, StWdataAck,
    StRdata, StRack, StStretch, StIgnore
  } state_e;

  // Two-flop synchronisers plus a history flop for edge detection.
  logic r_scl_s1, r_scl_s2, r_scl_prev;
  logic r_sda_s1, r_sda_s2, r_sda_prev;

  state_e      r_state, r_resume;
  logic [3:0]  r_bit_cnt;
  logic [6:0]  r_shift;
  logic [7:0]  r_tx;
  logic [1:0]  r_ptr;
  logic [31:0] r_regs;
  logic [7:0]  r_st_cnt;
  logic        r_mask;
  logic        r_sda_oe, r_scl_oe, r_wr_strobe, r_busy;

  logic        w_start, w_stop, w_rise, w_fall;
  logic [7:0]  w_shift_next;
  logic [7:0]  w_rd_byte;
  state_e      w_ack_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scl_s1   <= 1'b1;
      r_scl_s2   <= 1'b1;
      r_scl_prev <= 1'b1;
      r_sda_s1   <= 1'b1;
      r_sda_s2   <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_s1   <= scl_i;
      r_scl_s2   <= r_scl_s1;
      r_scl_prev <= r_scl_s2;
      r_sda_s1   <= sda_i;
      r_sda_s2   <= r_sda_s1;
      r_sda_prev <= r_sda_s2;
    end
  end

  assign w_start      = r_scl_s2 & r_scl_prev & r_sda_prev & ~r_sda_s2;
  assign w_stop       = r_scl_s2 & r_scl_prev & ~r_sda_prev & r_sda_s2;
  assign w_rise       = ~r_scl_prev & r_scl_s2;
  // After a stretch, falling edges stay masked until SCL is seen high again.
  assign w_fall       = r_scl_prev & ~r_scl_s2 & ~r_mask;
  assign w_shift_next = {r_shift, r_sda_s2};
  assign w_rd_byte    = r_regs[{r_ptr, 3'b000} +: 8];

  // Where to go once the target-driven ACK slot ends.
  always_comb begin
    w_ack_next = StWdata;
    if (r_state == StAddrAck) begin
      w_ack_next = r_shift[0] ? StRdata : StPtr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_resume    <= StIdle;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_tx        <= '0;
      r_ptr       <= '0;
      r_regs      <= '0;
      r_st_cnt    <= '0;
      r_mask      <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_scl_oe    <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_wr_strobe <= 1'b0;
      if (r_mask && r_scl_s2) r_mask <= 1'b0;

      if (w_stop) begin
        r_state  <= StIdle;
        r_sda_oe <= 1'b0;
        r_scl_oe <= 1'b0;
        r_busy   <= 1'b0;
        r_mask   <= 1'b0;
      end else if (w_start) begin
        r_state   <= StAddr;
        r_bit_cnt <= '0;
        r_sda_oe  <= 1'b0;
        r_scl_oe  <= 1'b0;
        r_mask    <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle, StIgnore: begin
          end
          StAddr: begin
            if (w_rise && r_bit_cnt < 4'd8) begin
              r_shift   <= w_shift_next[6:0];
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == 4'd7) begin
                if (w_shift_next[7:1] == TARGET_ADDR) begin
                  r_busy <= 1'b1;
                end else begin
                  r_state <= StIgnore;
                  r_busy  <= 1'b0;
                end
              end
            end else if (w_fall && r_bit_cnt == 4'd8) begin
              r_state  <= StAddrAck;
              r_sda_oe <= 1'b1;
            end
          end
          StPtr: begin
            if (w_rise && r_bit_cnt < 4'd8) begin
              r_shift   <= w_shift_next[6:0];
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == 4'd7) r_ptr <= w_shift_next[1:0];
            end else if (w_fall && r_bit_cnt == 4'd8) begin
              r_state  <= StPtrAck;
              r_sda_oe <= 1'b1;
            end
          end
          StWdata: begin
            if (w_rise && r_bit_cnt < 4'd8) begin
              r_shift   <= w_shift_next[6:0];
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == 4'd7) begin
                r_regs[{r_ptr, 3'b000} +: 8] <= w_shift_next;
                r_wr_strobe <= 1'b1;
                r_ptr       <= r_ptr + 2'd1;
              end
            end else if (w_fall && r_bit_cnt == 4'd8) begin
              r_state  <= StWdataAck;
              r_sda_oe <= 1'b1;
            end
          end
          StAddrAck, StPtrAck, StWdataAck: begin
            if (w_fall) begin
              r_bit_cnt <= '0;
              // Read byte is latched here, and bit 7 goes out on this same edge.
              if (w_ack_next == StRdata) begin
                r_tx     <= {w_rd_byte[6:0], 1'b0};
                r_sda_oe <= ~w_rd_byte[7];
              end else begin
                r_sda_oe <= 1'b0;
              end
              if (stretch_cycles != 8'd0) begin
                r_state  <= StStretch;
                r_resume <= w_ack_next;
                r_st_cnt <= stretch_cycles - 8'd1;
                r_scl_oe <= 1'b1;
                r_mask   <= 1'b1;
              end else begin
                r_state <= w_ack_next;
              end
            end
          end
          StRdata: begin
            if (w_rise && r_bit_cnt < 4'd8) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_fall && r_bit_cnt == 4'd8) begin
              r_sda_oe  <= 1'b0;
              r_state   <= StRack;
              r_bit_cnt <= '0;
              r_ptr     <= r_ptr + 2'd1;
            end else if (w_fall && r_bit_cnt != 4'd0) begin
              r_sda_oe <= ~r_tx[7];
              r_tx     <= {r_tx[6:0], 1'b0};
            end
          end
          StRack: begin
            // r_bit_cnt == 1 records that the master acknowledged.
            if (w_rise) begin
              if (!r_sda_s2) begin
                r_bit_cnt <= 4'd1;
              end else begin
                r_state <= StIgnore;
                r_busy  <= 1'b0;
              end
            end else if (w_fall && r_bit_cnt == 4'd1) begin
              r_tx      <= {w_rd_byte[6:0], 1'b0};
              r_sda_oe  <= ~w_rd_byte[7];
              r_bit_cnt <= '0;
              r_state   <= StRdata;
            end
          end
          StStretch: begin
            if (r_st_cnt == 8'd0) begin
              r_scl_oe <= 1'b0;
              r_state  <= r_resume;
            end else begin
              r_st_cnt <= r_st_cnt - 8'd1;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign scl_oe    = r_scl_oe;
  assign sda_oe    = r_sda_oe;
  assign regs      = r_regs;
  assign wr_strobe = r_wr_strobe;
  assign busy      = r_busy;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Self-checking bench for i2c_target_regs: a bus master model drives open-drain
// lines; ACK bits, read bytes and stretch lengths are checked through queues.
module tb_i2c_target_regs;

  logic        clk;
  logic        rst;
  logic        m_scl, m_sda;
  logic        scl_oe, sda_oe, wr_strobe, busy;
  logic [31:0] regs;
  logic [7:0]  stretch_cycles;
  logic        w_scl, w_sda;

  assign w_scl = m_scl & ~scl_oe;
  assign w_sda = m_sda & ~sda_oe;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  i2c_target_regs #(.TARGET_ADDR(7'b0101010)) dut (
    .clk            (clk),
    .rst            (rst),
    .scl_i          (w_scl),
    .sda_i          (w_sda),
    .scl_oe         (scl_oe),
    .sda_oe         (sda_oe),
    .stretch_cycles (stretch_cycles),
    .regs           (regs),
    .wr_strobe      (wr_strobe),
    .busy           (busy)
  );

  int checks = 0;
  int errors = 0;

  logic ack_q[$];
  logic [7:0] rd_q[$];
  int stretch_q[$];

  int strobe_cnt = 0;
  int sda_seen   = 0;
  int busy_seen  = 0;
  int run        = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors sample on the falling clock edge, away from DUT updates.
  always @(negedge clk) begin
    if (wr_strobe) strobe_cnt++;
    if (sda_oe) sda_seen = 1;
    if (busy) busy_seen = 1;
    if (scl_oe) begin
      run++;
    end else if (run > 0) begin
      if (stretch_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stretch_unexpected: got %0d cycles required none", run);
      end else begin
        check("stretch_len", run, stretch_q.pop_front());
      end
      run = 0;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_release();
    int n;
    n = 0;
    m_scl = 1'b1;
    @(negedge clk);
    while (w_scl !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (w_scl !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL scl_release: got SCL %b required 1 within 2000 cycles", w_scl);
    end
  endtask

  task automatic clock_bit(input logic b, output logic s);
    m_scl = 1'b0;
    wait_clks(6);
    m_sda = b;
    wait_clks(6);
    scl_release();
    wait_clks(12);
    s = w_sda;
    m_scl = 1'b0;
  endtask

  task automatic start_cond();
    m_sda = 1'b1;
    wait_clks(6);
    scl_release();
    wait_clks(6);
    m_sda = 1'b0;
    wait_clks(6);
  endtask

  task automatic stop_cond();
    m_scl = 1'b0;
    wait_clks(6);
    m_sda = 1'b0;
    wait_clks(6);
    scl_release();
    wait_clks(6);
    m_sda = 1'b1;
    wait_clks(12);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack);
    logic s;
    ack_q.push_back(exp_ack);
    if (!exp_ack && stretch_cycles != 8'd0) stretch_q.push_back(int'(stretch_cycles));
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, s);
    check("ack_bit", {31'd0, s}, {31'd0, ack_q.pop_front()});
  endtask

  task automatic recv_byte(input logic [7:0] exp, input logic m_ack);
    logic s;
    logic [7:0] got;
    rd_q.push_back(exp);
    got = '0;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      got[i] = s;
    end
    clock_bit(~m_ack, s);
    check("read_byte", {24'd0, got}, {24'd0, rd_q.pop_front()});
  endtask

  task automatic clear_flags();
    strobe_cnt = 0;
    sda_seen   = 0;
    busy_seen  = 0;
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  ptr;
    logic [7:0]  data;
    logic        ack;
    logic [31:0] exp_regs;
    int          strobes;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic s;
    vecs[0] = '{8'h54, 8'h01, 8'hA5, 1'b0, 32'h0000A500, 1};
    vecs[1] = '{8'h54, 8'h00, 8'h3C, 1'b0, 32'h0000A53C, 1};
    vecs[2] = '{8'h54, 8'hFE, 8'h77, 1'b0, 32'h0077A53C, 1};
    vecs[3] = '{8'h56, 8'h03, 8'h99, 1'b1, 32'h0077A53C, 0};
    vecs[4] = '{8'h54, 8'h07, 8'hC3, 1'b0, 32'hC377A53C, 1};

    m_scl = 1'b1;
    m_sda = 1'b1;
    stretch_cycles = 8'd0;
    rst = 1'b1;
    #2 rst = 1'b0;
    wait_clks(3);
    check("rst_regs", regs, 32'h0);
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_scl_oe", {31'd0, scl_oe}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
    rst = 1'b1;
    wait_clks(8);

    // Table of single-byte write transactions, applied in order.
    for (int v = 0; v < 5; v++) begin
      clear_flags();
      start_cond();
      send_byte(vecs[v].addr, vecs[v].ack);
      send_byte(vecs[v].ptr, vecs[v].ack);
      send_byte(vecs[v].data, vecs[v].ack);
      stop_cond();
      wait_clks(4);
      check("vec_regs", regs, vecs[v].exp_regs);
      check("vec_strobes", strobe_cnt, vecs[v].strobes);
      check("vec_busy_seen", busy_seen, {31'd0, ~vecs[v].ack});
      check("vec_sda_seen", sda_seen, {31'd0, ~vecs[v].ack});
      check("vec_busy_after_stop", {31'd0, busy}, 32'd0);
    end

    // Pointer wrap: reg3 then reg0.
    clear_flags();
    start_cond();
    send_byte(8'h54, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    stop_cond();
    wait_clks(4);
    check("wrap_regs", regs, 32'h1177A522);
    check("wrap_strobes", strobe_cnt, 2);

    // Set reg1/reg2, then reposition pointer to 1 with a pointer-only write.
    start_cond();
    send_byte(8'h54, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h5A, 1'b0);
    stop_cond();
    start_cond();
    send_byte(8'h54, 1'b0);
    send_byte(8'h01, 1'b0);
    stop_cond();
    wait_clks(4);
    check("setup_regs", regs, 32'h115AA522);

    // Read two bytes (ACK then NACK), then a pointer-less read from ptr 3.
    clear_flags();
    start_cond();
    send_byte(8'h55, 1'b0);
    recv_byte(8'hA5, 1'b1);
    recv_byte(8'h5A, 1'b0);
    stop_cond();
    check("read_no_strobe", strobe_cnt, 0);
    start_cond();
    send_byte(8'h55, 1'b0);
    recv_byte(8'h11, 1'b0);
    stop_cond();
    wait_clks(4);
    check("read_regs_kept", regs, 32'h115AA522);

    // Clock stretching after each ACK.
    stretch_cycles = 8'd10;
    clear_flags();
    start_cond();
    send_byte(8'h54, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h66, 1'b0);
    stop_cond();
    wait_clks(4);
    check("stretch_regs", regs, 32'h1166A522);
    check("stretch_all_seen", stretch_q.size(), 0);
    stretch_cycles = 8'd0;

    // Reset in the middle of a data byte.
    start_cond();
    send_byte(8'h54, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 4; i++) clock_bit(1'b1, s);
    rst = 1'b0;
    #1;
    check("midrst_regs", regs, 32'h0);
    check("midrst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("midrst_scl_oe", {31'd0, scl_oe}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    m_scl = 1'b1;
    m_sda = 1'b1;
    wait_clks(5);
    rst = 1'b1;
    wait_clks(8);
    clear_flags();
    start_cond();
    send_byte(8'h54, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h42, 1'b0);
    stop_cond();
    wait_clks(4);
    check("postrst_regs", regs, 32'h00420000);
    check("postrst_strobes", strobe_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
